// File: rtl/traffic_display_driver.sv
// Two-channel countdown display driver: binary-to-BCD converter FSM, display
// registers, 4-digit multiplexed scan, lamp echo and sticky lamp-conflict fault.
module traffic_display_driver #(
   parameter int SCAN_DIV = 1000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] count1,
   input  logic [7:0] count2,
   input  logic [2:0] light1,
   input  logic [2:0] light2,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic [2:0] led1,
   output logic [2:0] led2,
   output logic       fault,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, LOAD = 2'd2} state_t;

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   state_t            state, state_nxt;
   logic [7:0]        last1, last2, cap1, cap2;
   logic [11:0]       bcd1, bcd2;
   logic [2:0]        step;
   logic              force_cvt, start;
   logic [3:0][3:0]   disp;
   logic              dash1, dash2;
   logic [15:0]       scan_cnt;
   logic [1:0]        idx;
   logic              fault_nxt;

   // One double-dabble step on {bcd[11:0], bin[7:0]}.
   function automatic logic [19:0] dd_step(input logic [19:0] v);
      logic [19:0] t;
      t = v;
      for (int i = 0; i < 3; i++)
         if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
      return {t[18:0], 1'b0};
   endfunction

   // Code 4'hF is the blank digit.
   function automatic logic [3:0] tens_code(input logic [11:0] b);
      return (BLANK_LZ && b[11:8] == 4'd0 && b[7:4] == 4'd0) ? 4'hF : b[7:4];
   endfunction

   function automatic logic [6:0] seg_dec(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return SEG_BLANK;
      endcase
   endfunction

   function automatic logic onehot3(input logic [2:0] l);
      return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
   endfunction

   assign start = (state == IDLE) && ((count1 != last1) || (count2 != last2) || force_cvt);
   assign busy  = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CONV;
         CONV:    if (step == 3'd7) state_nxt = LOAD;
         LOAD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last1     <= '0;
         last2     <= '0;
         cap1      <= '0;
         cap2      <= '0;
         bcd1      <= '0;
         bcd2      <= '0;
         step      <= '0;
         force_cvt <= 1'b1;
         disp      <= {4{4'hF}};
         dash1     <= 1'b0;
         dash2     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cap1      <= count1;
               cap2      <= count2;
               last1     <= count1;
               last2     <= count2;
               bcd1      <= '0;
               bcd2      <= '0;
               step      <= '0;
               force_cvt <= 1'b0;
            end
            CONV: begin
               {bcd1, cap1} <= dd_step({bcd1, cap1});
               {bcd2, cap2} <= dd_step({bcd2, cap2});
               step         <= step + 3'd1;
            end
            LOAD: begin
               // All four digits and both dash flags update together.
               disp[3] <= tens_code(bcd1);
               disp[2] <= bcd1[3:0];
               disp[1] <= tens_code(bcd2);
               disp[0] <= bcd2[3:0];
               dash1   <= (bcd1[11:8] != 4'd0);
               dash2   <= (bcd2[11:8] != 4'd0);
            end
            default: ;
         endcase
      end
   end

   // Fault takes effect on the same edge it is detected, for leds and digits alike.
   assign fault_nxt = fault || !onehot3(light1) || !onehot3(light2) ||
                      ((light1 != 3'b100) && (light2 != 3'b100));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault <= 1'b0;
         led1  <= '0;
         led2  <= '0;
      end else begin
         fault <= fault_nxt;
         led1  <= fault_nxt ? 3'b100 : light1;
         led2  <= fault_nxt ? 3'b100 : light2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= '0;
         an       <= 4'hF;
         seg      <= SEG_BLANK;
      end else begin
         if (scan_cnt == 16'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + 16'd1;
         end
         an  <= ~(4'b0001 << idx);
         seg <= (fault_nxt || (idx[1] ? dash1 : dash2)) ? SEG_DASH : seg_dec(disp[idx]);
      end
   end

endmodule

// File: tb/tb_traffic_display_driver.sv
// Directed bench for traffic_display_driver with a short scan period so the
// digit multiplex can be observed in a few cycles.
module tb_traffic_display_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] count1, count2;
   logic [2:0] light1, light2;
   logic [6:0] seg;
   logic [3:0] an;
   logic [2:0] led1, led2;
   logic       fault, busy;

   int errors = 0;
   int checks = 0;

   traffic_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .rst(rst), .count1(count1), .count2(count2),
      .light1(light1), .light2(light2), .seg(seg), .an(an),
      .led1(led1), .led2(led2), .fault(fault), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] c1, c2;
      logic [6:0] s3, s2, s1, s0;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Collect the segment pattern shown under each digit enable over a full scan.
   task automatic read_digits(output logic [3:0][6:0] d);
      d = {4{7'h55}};
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         for (int b = 0; b < 4; b++)
            if (an == ~(4'b0001 << b)) d[b] = seg;
      end
   endtask

   logic [3:0][6:0] d;
   logic [3:0]      an_exp;
   int              busy_n;
   logic [22:1]     trace, trace_exp;

   initial begin
      tbl[0] = '{c1: 8'd20,  c2: 8'd15,  s3: 7'h24, s2: 7'h40, s1: 7'h79, s0: 7'h12};
      tbl[1] = '{c1: 8'd5,   c2: 8'd0,   s3: 7'h7F, s2: 7'h12, s1: 7'h7F, s0: 7'h40};
      tbl[2] = '{c1: 8'd150, c2: 8'd7,   s3: 7'h3F, s2: 7'h3F, s1: 7'h7F, s0: 7'h78};
      tbl[3] = '{c1: 8'd99,  c2: 8'd100, s3: 7'h10, s2: 7'h10, s1: 7'h3F, s0: 7'h3F};
      tbl[4] = '{c1: 8'd255, c2: 8'd9,   s3: 7'h3F, s2: 7'h3F, s1: 7'h7F, s0: 7'h10};
      tbl[5] = '{c1: 8'd86,  c2: 8'd43,  s3: 7'h00, s2: 7'h02, s1: 7'h19, s0: 7'h30};
      tbl[6] = '{c1: 8'd10,  c2: 8'd60,  s3: 7'h79, s2: 7'h40, s1: 7'h02, s0: 7'h40};

      count1 = 8'd20; count2 = 8'd15;
      light1 = 3'b100; light2 = 3'b001;

      // Reset state, asserted asynchronously before the first clock edge.
      #2 rst = 1'b1;
      #1;
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_led1", 32'(led1), 32'd0);
      chk("rst_led2", 32'(led2), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Release: forced conversion busy for 9 cycles, scan each digit held 4 cycles.
      busy_n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (busy) busy_n++;
         an_exp = ~(4'b0001 << (((k - 1) / 4) % 4));
         chk("scan_an", 32'(an), 32'(an_exp));
         if (k == 1) chk("blank_after_rst", 32'(seg), 32'h7F);
      end
      chk("busy_cycles", 32'(busy_n), 32'd9);

      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         count1 = tbl[i].c1; count2 = tbl[i].c2;
         repeat (12) @(negedge clk);
         read_digits(d);
         chk($sformatf("vec%0d_ch1_tens", i), 32'(d[3]), 32'(tbl[i].s3));
         chk($sformatf("vec%0d_ch1_ones", i), 32'(d[2]), 32'(tbl[i].s2));
         chk($sformatf("vec%0d_ch2_tens", i), 32'(d[1]), 32'(tbl[i].s1));
         chk($sformatf("vec%0d_ch2_ones", i), 32'(d[0]), 32'(tbl[i].s0));
      end

      // Input change during a conversion: ignored until the idle cycle after LOAD.
      @(negedge clk);
      count1 = 8'd20; count2 = 8'd20;
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         trace[k] = busy;
         trace_exp[k] = (k <= 9) || (k >= 11 && k <= 19);
         if (k == 3) count1 = 8'd19;
      end
      chk("busy_retrigger", 32'(trace), 32'(trace_exp));
      read_digits(d);
      chk("retrig_ch1_tens", 32'(d[3]), 32'h79);
      chk("retrig_ch1_ones", 32'(d[2]), 32'h10);
      chk("retrig_ch2_tens", 32'(d[1]), 32'h24);
      chk("retrig_ch2_ones", 32'(d[0]), 32'h40);

      // Lamp conflict for a single cycle, then legal lamps again.
      chk("fault_before", 32'(fault), 32'd0);
      light1 = 3'b001; light2 = 3'b001;
      @(negedge clk);
      chk("fault_set", 32'(fault), 32'd1);
      chk("fault_led1", 32'(led1), 32'h4);
      chk("fault_led2", 32'(led2), 32'h4);
      light1 = 3'b100; light2 = 3'b001;
      repeat (5) @(negedge clk);
      chk("fault_sticky", 32'(fault), 32'd1);
      chk("fault_led1_hold", 32'(led1), 32'h4);
      chk("fault_led2_hold", 32'(led2), 32'h4);
      read_digits(d);
      for (int b = 0; b < 4; b++)
         chk($sformatf("fault_dash%0d", b), 32'(d[b]), 32'h3F);

      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("fault_cleared", 32'(fault), 32'd0);

      // Reset in the middle of a conversion aborts it and blanks the digits.
      count1 = 8'd42; count2 = 8'd42;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_an", 32'(an), 32'hF);
      chk("abort_seg", 32'(seg), 32'h7F);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("abort_blank", 32'(seg), 32'h7F);
      repeat (12) @(negedge clk);
      read_digits(d);
      chk("after_abort_ch1_tens", 32'(d[3]), 32'h19);
      chk("after_abort_ch1_ones", 32'(d[2]), 32'h24);
      chk("after_abort_ch2_tens", 32'(d[1]), 32'h19);
      chk("after_abort_ch2_ones", 32'(d[0]), 32'h24);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
